// File: rtl/pixel_mem_reader_if.sv
// Pixel memory port-A and pixel stream bundle used by pixel_mem_reader.
// master = reader side, slave = memory/consumer side.
interface pixel_mem_reader_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
) ();
   logic              sel;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_q;
   logic [DATA_W-1:0] px_data;
   logic              px_valid;
   logic              px_ready;
   logic              px_last;

   modport master (
      output sel, mem_addr, px_data, px_valid, px_last,
      input  mem_q, px_ready
   );

   modport slave (
      input  sel, mem_addr, px_data, px_valid, px_last,
      output mem_q, px_ready
   );
endinterface

// File: rtl/pixel_mem_reader.sv
// pixel_mem_reader: walks a wrapping address range on pixel memory port A,
// absorbs the one-cycle read latency with a 2-entry FIFO and streams the
// pixels out over valid/ready with a last marker.
// Optional feature macro: PIXEL_MEM_READER_ABORT_EN (adds the abort input).
module pixel_mem_reader #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
`ifdef PIXEL_MEM_READER_ABORT_EN
   input  logic              abort,
`endif
   output logic              busy,
   output logic              done,
   pixel_mem_reader_if.master bus
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] addr_reg;
   logic [ADDR_W:0]   remaining_reg;
   logic              rd_pending_reg;
   logic              rd_last_reg;
   logic [1:0]        count_reg;
   logic              rd_ptr_reg, wr_ptr_reg;
   logic              done_reg;
   logic [DATA_W-1:0] fifo_data [2];
   logic              fifo_tag  [2];

   logic              pop, issue, head_last, abort_hit;
   logic [ADDR_W:0]   len_clamped;

`ifdef PIXEL_MEM_READER_ABORT_EN
   assign abort_hit = abort && (state_reg != IDLE);
`else
   assign abort_hit = 1'b0;
`endif

   assign len_clamped = (length > DEPTH) ? DEPTH : length;
   assign pop         = (count_reg != 2'd0) && bus.px_ready;
   assign head_last   = (count_reg != 2'd0) && fifo_tag[rd_ptr_reg];

   assign busy         = (state_reg != IDLE);
   assign done         = done_reg;
   assign bus.sel      = busy;
   assign bus.mem_addr = addr_reg;
   assign bus.px_valid = (count_reg != 2'd0);
   assign bus.px_data  = (count_reg != 2'd0) ? fifo_data[rd_ptr_reg] : '0;
   assign bus.px_last  = head_last;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Next-state and read-issue decision; an issue is allowed only when the
   // FIFO is guaranteed a free slot for the data returning next cycle.
   always_comb begin
      state_next = state_reg;
      issue      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start && (len_clamped != '0)) state_next = READ;
         end
         READ: begin
            if ((remaining_reg != '0) &&
                (({1'b0, count_reg} + {2'b00, rd_pending_reg}) < (3'd2 + {2'b00, pop})))
               issue = 1'b1;
            if ((remaining_reg == '0) || (issue && (remaining_reg == 1)))
               state_next = DRAIN;
         end
         DRAIN: begin
            if (pop && head_last) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (abort_hit) begin
         state_next = IDLE;
         issue      = 1'b0;
      end
   end

   // Address walk, pending-read tracking, FIFO occupancy and done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_reg       <= '0;
         remaining_reg  <= '0;
         rd_pending_reg <= 1'b0;
         rd_last_reg    <= 1'b0;
         count_reg      <= 2'd0;
         rd_ptr_reg     <= 1'b0;
         wr_ptr_reg     <= 1'b0;
         done_reg       <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if ((state_reg == IDLE) && start) begin
            addr_reg      <= base_addr;
            remaining_reg <= len_clamped;
            if (len_clamped == '0) done_reg <= 1'b1;
         end
         rd_pending_reg <= issue;
         if (issue) begin
            addr_reg      <= addr_reg + 1'b1;
            remaining_reg <= remaining_reg - 1'b1;
            rd_last_reg   <= (remaining_reg == 1);
         end
         if (rd_pending_reg) wr_ptr_reg <= ~wr_ptr_reg;
         if (pop)            rd_ptr_reg <= ~rd_ptr_reg;
         count_reg <= count_reg + {1'b0, rd_pending_reg} - {1'b0, pop};
         if ((state_reg == DRAIN) && pop && head_last) done_reg <= 1'b1;
         if (abort_hit) begin
            count_reg      <= 2'd0;
            rd_pending_reg <= 1'b0;
            rd_ptr_reg     <= 1'b0;
            wr_ptr_reg     <= 1'b0;
            remaining_reg  <= '0;
            done_reg       <= 1'b1;
         end
      end
   end

   // FIFO storage: captures the memory read data the cycle after an issue.
   always_ff @(posedge clk) begin
      if (rd_pending_reg) begin
         fifo_data[wr_ptr_reg] <= bus.mem_q;
         fifo_tag[wr_ptr_reg]  <= rd_last_reg;
      end
   end

endmodule

// File: tb/tb_pixel_mem_reader.sv
// Self-checking bench for pixel_mem_reader: a memory model, a scoreboard
// queue filled when a run is started, and a monitor that checks every
// transfer against it.
module tb_pixel_mem_reader;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W:0]   length = '0;
   logic              busy, done;
`ifdef PIXEL_MEM_READER_ABORT_EN
   logic              abort = 1'b0;
`endif

   pixel_mem_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   pixel_mem_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
`ifdef PIXEL_MEM_READER_ABORT_EN
      .abort     (abort),
`endif
      .busy      (busy),
      .done      (done),
      .bus       (bus.master)
   );

   always #5 clk = ~clk;

   logic [DATA_W-1:0] mem [DEPTH];
   always @(posedge clk) bus.mem_q <= mem[bus.mem_addr];

   int n_cmp = 0;
   int n_bad = 0;
   int xfer_cnt = 0;
   logic [DATA_W:0] exp_q [$];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   function automatic bit ready_for(input int mode, input int c);
      if (mode == 0) return 1'b1;
      if (mode == 1) return ((c % 4) == 0) || ((c % 4) == 3);
      return 1'($urandom_range(0, 1));
   endfunction

   // Monitor: checks each transfer against the scoreboard and data stability
   // across stalls.
   bit              stall_prev = 1'b0;
   logic [DATA_W-1:0] held;
   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("valid_held", int'(bus.px_valid), 1);
            check("data_stable", int'(bus.px_data), int'(held));
         end
         if (bus.px_valid && bus.px_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_pixel", int'(bus.px_data), -1);
            end else begin
               logic [DATA_W:0] e;
               e = exp_q.pop_front();
               check("px_data", int'(bus.px_data), int'(e[DATA_W-1:0]));
               check("px_last", int'(bus.px_last), int'(e[DATA_W]));
            end
            xfer_cnt++;
         end
         stall_prev = bus.px_valid && !bus.px_ready;
         held       = bus.px_data;
      end
   end

   task automatic push_expect(input int base, input int len);
      int n;
      n = (len > DEPTH) ? DEPTH : len;
      for (int i = 0; i < n; i++)
         exp_q.push_back({(i == n - 1), mem[(base + i) % DEPTH]});
   endtask

   // One run: start, drive ready per mode, wait for done, check timing.
   task automatic run(input int base, input int len, input int mode, input bit timed);
      int n, cyc, first, done_cyc;
      n = (len > DEPTH) ? DEPTH : len;
      push_expect(base, len);
      @(posedge clk); #1;
      start = 1'b1; base_addr = ADDR_W'(base); length = (ADDR_W+1)'(len);
      bus.px_ready = ready_for(mode, 0);
      cyc = 0; first = -1; done_cyc = -1;
      while (cyc < 4000 && done_cyc < 0) begin
         @(posedge clk); #1;
         cyc++;
         start = 1'b0;
         if (cyc == 1) begin
            check("busy_c1", int'(busy), (n != 0) ? 1 : 0);
            check("sel_c1", int'(bus.sel), (n != 0) ? 1 : 0);
            if (n != 0) check("mem_addr_c1", int'(bus.mem_addr), base);
         end
         if (first < 0 && bus.px_valid) first = cyc;
         if (done) begin
            done_cyc = cyc;
            check("busy_at_done", int'(busy), 0);
         end
         bus.px_ready = ready_for(mode, cyc);
      end
      check("done_seen", (done_cyc >= 0) ? 1 : 0, 1);
      if (timed) begin
         if (n != 0) check("first_valid_cycle", first, 3);
         else        check("no_valid_len0", first, -1);
         check("done_cycle", done_cyc, (n != 0) ? n + 3 : 1);
      end
      check("scoreboard_empty", exp_q.size(), 0);
      $display("run base=0x%03h len=%0d mode=%0d first=%0d done_cycle=%0d",
               base, len, mode, first, done_cyc);
      exp_q.delete();
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_sel"}, int'(bus.sel), 0);
      check({tag, "_mem_addr"}, int'(bus.mem_addr), 0);
      check({tag, "_px_valid"}, int'(bus.px_valid), 0);
      check({tag, "_px_data"}, int'(bus.px_data), 0);
      check({tag, "_px_last"}, int'(bus.px_last), 0);
   endtask

   initial begin
      int x0, guard;
      bus.px_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
      for (int i = 0; i < 4; i++) mem[16 + i] = DATA_W'(8'hA0 + i);

      repeat (3) @(posedge clk);
      #1 check_idle_outputs("reset");
      rst = 1'b0;
      @(posedge clk); #1 check_idle_outputs("idle");

      run(0, 0, 0, 1'b1);
      run(16, 4, 0, 1'b1);
      run(10'h3FE, 4, 0, 1'b1);
      run(int'($urandom_range(0, DEPTH - 1)), 8, 1, 1'b0);

      // Reset in the middle of a 10-pixel run after 3 transfers.
      push_expect(100, 10);
      @(posedge clk); #1;
      start = 1'b1; base_addr = 10'd100; length = 11'd10; bus.px_ready = 1'b1;
      x0 = xfer_cnt; guard = 0;
      @(posedge clk); #1 start = 1'b0;
      while ((xfer_cnt - x0) < 3 && guard < 50) begin
         @(posedge clk); #1 guard++;
      end
      check("three_xfers_before_reset", ((xfer_cnt - x0) >= 3) ? 1 : 0, 1);
      rst = 1'b1;
      @(posedge clk); #1 check_idle_outputs("midrun_reset");
      rst = 1'b0;
      exp_q.delete();
      $display("run base=0x064 len=10 reset after %0d transfers", xfer_cnt - x0);
      @(posedge clk); #1 check("no_done_after_reset", int'(done), 0);

      run(int'($urandom_range(0, DEPTH - 1)), 10, 0, 1'b1);
      for (int k = 0; k < 6; k++)
         run(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 40)), 2, 1'b0);
      run(int'($urandom_range(0, DEPTH - 1)), 11'h7FF, 0, 1'b1);

`ifdef PIXEL_MEM_READER_ABORT_EN
      begin
         int c;
         push_expect(200, 16);
         @(posedge clk); #1;
         start = 1'b1; base_addr = 10'd200; length = 11'd16; bus.px_ready = 1'b1;
         c = 0;
         while (c < 5) begin
            @(posedge clk); #1 c++;
            start = 1'b0;
         end
         abort = 1'b1;
         @(posedge clk); #1 abort = 1'b0;
         check("abort_px_valid", int'(bus.px_valid), 0);
         check("abort_done", int'(done), 1);
         check("abort_busy", int'(busy), 0);
         @(posedge clk); #1 check("abort_done_once", int'(done), 0);
         exp_q.delete();
         $display("run base=0x0c8 len=16 aborted at cycle 5");
      end
`endif

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/pixel_mem_reader.md
# pixel_mem_reader

Streaming read engine for the 1024 x 8-bit dual-port pixel memory. On a start pulse it walks a contiguous, wrapping address range on memory port A, absorbs the memory's one-cycle read latency, and delivers pixels over a valid/ready stream with a last marker. It is the read-side counterpart of the pixel loader. While it runs, it owns the port-A address mux through its `sel` output.

## Interface
Parameters:
- ADDR_W, 10, memory address width; memory depth = 2^ADDR_W
- DATA_W, 8, pixel width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  single-cycle request; sampled only in IDLE
- base_addr  in  ADDR_W  first pixel address; latched on accepted start
- length  in  ADDR_W+1  pixel count; latched on accepted start
- sel  out  1  port-A address-mux select; 1 = reader owns the port
- mem_addr  out  ADDR_W  port-A read address
- mem_q  in  DATA_W  port-A read data; valid one cycle after mem_addr
- px_data  out  DATA_W  output pixel
- px_valid  out  1  px_data valid
- px_ready  in  1  consumer accepts; transfer = px_valid & px_ready
- px_last  out  1  high with the final pixel of the run
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run completion

## Operation
- States: IDLE, READ, DRAIN.
- IDLE to READ: taken when start = 1. The block latches base_addr and length into the address and remaining registers.
  - A latched length of 0 goes directly to the done pulse (see below) and emits no pixels.
  - A latched length greater than 2^ADDR_W is clamped to 2^ADDR_W.
- READ, issue rule:
  - The block issues one address per cycle while remaining > 0 and (fifo_count + rd_pending − pop) < 2.
  - pop = px_valid & px_ready in the current cycle.
  - Issuing sets rd_pending for the next cycle, increments the address modulo 2^ADDR_W, and decrements remaining.
- rd_pending = 1 pushes mem_q into a 2-entry output FIFO at the end of that cycle. The FIFO cannot overflow, by the issue rule.
- READ to DRAIN: taken when remaining reaches 0.
- DRAIN to IDLE: taken on the transfer that has px_last = 1. done pulses in the following cycle.
- px_data and px_valid come from the FIFO head. px_last = 1 when the head entry is the final pixel of the run, tracked by a tag bit stored per entry.
- sel = busy. mem_addr holds the current address register at all times.
- start while busy is ignored.
- px_data is stable while px_valid = 1 and px_ready = 0.

## Timing
- All outputs are 0 after reset. The address, remaining, FIFO count, and rd_pending registers are also cleared.
- Reset in any state returns the block to IDLE in the next cycle, discards FIFO contents, and produces no done pulse.
- Cycle-level sequence for a start seen at cycle 0:
  - busy = sel = 1 from cycle 1.
  - mem_addr = base during cycle 1.
  - The first pixel appears with px_valid = 1 at cycle 3.
- Throughput: with px_ready held high, the block sustains 1 pixel per cycle. An N-pixel run's last transfer occurs at cycle N+2.
- Completion: done = 1 and busy = 0 in the cycle after the last transfer. The block is in IDLE and can accept start in that same cycle.
- Zero length: done pulses at cycle 1, busy stays 0, and no memory access occurs.
- Backpressure: with px_ready = 0, at most 2 pixels are buffered and issuing stalls. Memory data is never lost and no address is skipped.

## Configuration
- PIXEL_MEM_READER_ABORT_EN:
  - Defined: adds input `abort` (1 bit). abort = 1 in READ or DRAIN returns the block to IDLE in the next cycle and flushes the FIFO. A pending read is discarded, px_valid drops, and done pulses once. No px_last is emitted.
  - Undefined: the port does not exist, and a run always completes in full.

## Test plan
- Reset then idle: all outputs 0, mem_addr = 0; start with length = 0 → done at cycle 1, px_valid never asserts.
- base = 0x010, length = 4, memory holds 0xA0..0xA3, px_ready held 1 → pixels A0,A1,A2,A3 on cycles 3–6, px_last on A3, done on cycle 7.
- base = 0x3FE, length = 4 → addresses 0x3FE, 0x3FF, 0x000, 0x001 in order (wrap-around).
- length = 8, px_ready toggled 1,0,0,1,… → all 8 pixels delivered in order with no duplicates, FIFO never exceeds 2, px_data stable during stalls.
- rst asserted mid-run (after 3 transfers of 10) → next cycle: all outputs 0, no done; a fresh start then completes normally.
- With PIXEL_MEM_READER_ABORT_EN defined, abort asserted at cycle 5 of a length = 16 run → px_valid = 0 and done = 1 at cycle 6, busy = 0 after.
